bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-requester arbiter and sequencer for the shared 2:1 data multiplexer on the processor's internal bus. It accepts request/release handshakes from two bus masters and grants the bus with round-robin fairness. It drives the multiplexer `select` line and registers the selected word onto the bus with a valid flag.

## Interface
- `inputWidth`, default 8: width of each data input and of `busOut`.
- `maxHold`, default 15: maximum consecutive owned cycles before preemption. Legal range 1..255. Used only with `BUS_ARBITER_TIMEOUT_EN`.

- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0` input 1: requester 0 wants the bus; held high for the whole transfer.
- `req1` input 1: requester 1 wants the bus; held high for the whole transfer.
- `data0` input `inputWidth`: requester 0 data.
- `data1` input `inputWidth`: requester 1 data.
- `grant0` output 1: registered; requester 0 owns the bus.
- `grant1` output 1: registered; requester 1 owns the bus.
- `select` output 1: registered multiplexer select, 0 = `data0`, 1 = `data1`.
- `busOut` output `inputWidth`: registered multiplexer output.
- `busValid` output 1: registered; `busOut` carries an owner's data.

## Operation
- States: IDLE, OWN0, OWN1. `grant0` = (state == OWN0) and `grant1` = (state == OWN1). The two grants are never high together.
- Register `lastGrant` (1 bit) holds the index of the most recent owner. Reset value 1, so requester 0 wins the first tie.
- IDLE transitions:
  - `req0` only -> OWN0.
  - `req1` only -> OWN1.
  - Both requests high -> OWN of the index ≠ `lastGrant`.
  - No requests -> stay in IDLE.
- OWNx while `reqx` is high: stay in OWNx (subject to the timeout rule under Configuration).
- OWNx when `reqx` drops:
  - Other request high -> go directly to OWN of the other index. No IDLE bubble.
  - Otherwise -> IDLE.
- On every entry into OWNx: `lastGrant` <= x and `select` <= x.
- In IDLE, `select` holds its last value.
- Data path, evaluated each cycle:
  - `busOut` <= `select ? data1 : data0`, using the current registered `select`.
  - `busValid` <= (state != IDLE).
  - When `busValid` is 0, `busOut` is don't-care but must still follow the mux.
- Requests from a non-owner while the bus is held are not latched; the requester must keep its request high until granted.

## Timing
- Reset values: `grant0`=0, `grant1`=0, `select`=0, `busOut`=0, `busValid`=0, state=IDLE, `lastGrant`=1, hold counter=0.
- Reset asserted mid-transfer: all of the above take effect at the next edge, regardless of requests. The first grant can come no earlier than the edge after `reset` deasserts.
- Grant latency: a request sampled high at edge n in IDLE produces a grant and `select` at edge n+1.
- Data latency: the first owned word appears on `busOut` with `busValid`=1 at edge n+2.
- Handoff: owner drops its request before edge n -> the other grant is asserted at edge n. `busValid` stays high continuously across the handoff, and `busOut` switches source one cycle after `select`.
- Release to IDLE: grant drops at the edge that samples the request low. `busValid` drops one edge later.

## Configuration
- Macro: `BUS_ARBITER_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on each OWN entry and increments each cycle in OWN.
  - When the counter equals `maxHold`-1 and the other request is high, the next edge forces a handoff to the other requester. The current owner's grant drops even though its request is still high.
  - If the other request is low, the counter saturates and no preemption occurs.
  - A preempted requester re-arbitrates normally.
- Not defined: no counter is instantiated, and the owner holds the bus for as long as its request stays high.

## Test plan
- Reset, then `req0`=1 alone with `data0`=8'hFF: `grant0`=1 at the next edge; `busOut`=8'hFF and `busValid`=1 one edge later; `grant1`=0 throughout.
- `req0` and `req1` rise together after reset: `grant0` first. Drop `req0`: `grant1`=1 at the same edge `grant0` falls. `select` goes 0->1 and `busOut` goes 8'hFF->8'hAA with `data1`=8'hAA, with no `busValid` gap.
- Repeated simultaneous requests, each released after 3 cycles: grants strictly alternate 0,1,0,1.
- `reset` pulsed for one cycle while `grant1`=1: all outputs are 0 next edge. With both requests still high, `grant0` wins afterward.
- With `BUS_ARBITER_TIMEOUT_EN` and `maxHold`=4, `req0` and `req1` held high continuously: grant alternates every 4 cycles. Without the macro, `grant0` stays high indefinitely.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter driving a registered 2:1 data mux.
// Optional hold-time preemption is enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int inputWidth = 8,
    parameter int maxHold    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [inputWidth-1:0] data0,
    input  logic [inputWidth-1:0] data1,
    output logic                  grant0,
    output logic                  grant1,
    output logic                  select,
    output logic [inputWidth-1:0] busOut,
    output logic                  busValid
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state;
    state_t stateNext;
    logic   lastGrant;
    logic   entering;
    logic   preempt;

    if (maxHold < 1 || maxHold > 255) begin : g_bad_hold
        $error("bus_arbiter: maxHold must be in 1..255");
    end

    assign entering = (stateNext != state) && (stateNext != IDLE);

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] holdLast = 8'(maxHold - 1);
    logic [7:0] holdCount;

    // Saturating at holdLast keeps preemption armed until the other side asks.
    assign preempt = (holdCount == holdLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            holdCount <= 8'd0;
        end else if (entering) begin
            holdCount <= 8'd0;
        end else if (state != IDLE && holdCount != holdLast) begin
            holdCount <= holdCount + 8'd1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns stateNext and no latch is inferred.
        stateNext = state;
        case (state)
            IDLE: begin
                if (req0 && req1) stateNext = lastGrant ? OWN0 : OWN1;
                else if (req0)    stateNext = OWN0;
                else if (req1)    stateNext = OWN1;
            end
            OWN0: begin
                if (!req0 || (preempt && req1)) stateNext = req1 ? OWN1 : IDLE;
            end
            OWN1: begin
                if (!req1 || (preempt && req0)) stateNext = req0 ? OWN0 : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The mux output uses the select already registered, so data trails select by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            select    <= 1'b0;
            busOut    <= '0;
            busValid  <= 1'b0;
        end else begin
            // NOTE: non-blocking so busOut sees the pre-edge select, not the one updated here.
            state    <= stateNext;
            busOut   <= select ? data1 : data0;
            busValid <= (state != IDLE);
            if (entering) begin
                lastGrant <= (stateNext == OWN1);
                select    <= (stateNext == OWN1);
            end
        end
    end

    assign grant0 = (state == OWN0);
    assign grant1 = (state == OWN1);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand sequences,
// and randomized requests compared against a rule-level reference model.
module tb_bus_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         grant0, grant1, select, busValid;
    logic [W-1:0] busOut;

    int total = 0;
    int bad   = 0;

    // Reference model: owner is -1 when nobody holds the bus.
    int           m_owner;
    int           m_last;
    int           m_sel;
    int           m_hold;
    logic [W-1:0] m_bus;
    logic         m_valid;

    typedef struct {
        logic         rst;
        logic         r0;
        logic         r1;
        logic         g0;
        logic         g1;
        logic         sel;
        logic         vld;
        logic [W-1:0] bus;
    } vec_t;

    vec_t vecs[14];

    bus_arbiter #(.inputWidth(W), .maxHold(MH)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .grant0(grant0), .grant1(grant1),
        .select(select), .busOut(busOut), .busValid(busValid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit timeout_on();
`ifdef BUS_ARBITER_TIMEOUT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one edge using the inputs the DUT is about to sample.
    task automatic model_step();
        int  nxt;
        bit  rq[2];
        rq[0] = req0;
        rq[1] = req1;
        if (reset) begin
            m_owner = -1; m_last = 1; m_sel = 0; m_hold = 0;
            m_bus = '0; m_valid = 1'b0;
            return;
        end
        m_bus   = (m_sel == 1) ? data1 : data0;
        m_valid = (m_owner != -1);
        if (m_owner == -1) begin
            if (rq[0] && rq[1]) nxt = 1 - m_last;
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else begin
            int o = m_owner;
            bool_t: begin end
            if (rq[o] && !(timeout_on() && rq[1-o] && m_hold == MH - 1)) nxt = o;
            else if (rq[1-o]) nxt = 1 - o;
            else              nxt = -1;
        end
        if (nxt != -1 && nxt != m_owner) begin
            m_hold = 0;
            m_last = nxt;
            m_sel  = nxt;
        end else if (nxt != -1 && m_hold < MH - 1) begin
            m_hold++;
        end
        m_owner = nxt;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_g0"},  grant0,   (m_owner == 0));
        check({tag, "_g1"},  grant1,   (m_owner == 1));
        check({tag, "_sel"}, select,   m_sel[0]);
        check({tag, "_vld"}, busValid, m_valid);
        check({tag, "_bus"}, busOut,   m_bus);
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = 8'hFF; data1 = 8'hAA;

        //            rst   r0    r1    g0    g1    sel   vld   bus
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
            cycle();
            check($sformatf("vec%0d_g0", i),  grant0,   vecs[i].g0);
            check($sformatf("vec%0d_g1", i),  grant1,   vecs[i].g1);
            check($sformatf("vec%0d_sel", i), select,   vecs[i].sel);
            check($sformatf("vec%0d_vld", i), busValid, vecs[i].vld);
            check($sformatf("vec%0d_bus", i), busOut,   vecs[i].bus);
        end

        // Simultaneous requests released after 3 owned cycles alternate 0,1,0,1.
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req0 = 1'b1; req1 = 1'b1;
            cycle();
            check($sformatf("alt%0d_g0", k), grant0, (k % 2 == 0));
            check($sformatf("alt%0d_g1", k), grant1, (k % 2 == 1));
            cycle(); cycle();
            req0 = 1'b0; req1 = 1'b0;
            cycle(); cycle();
        end

        // Continuous contention: sticky owner by default, rotation every MH cycles with timeout.
        reset = 1'b1; cycle(); reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            cycle();
`ifdef BUS_ARBITER_TIMEOUT_EN
            check($sformatf("rot%0d_g0", c), grant0, (((c - 1) / MH) % 2 == 0));
            check($sformatf("rot%0d_g1", c), grant1, (((c - 1) / MH) % 2 == 1));
`else
            check($sformatf("hold%0d_g0", c), grant0, 1'b1);
            check($sformatf("hold%0d_g1", c), grant1, 1'b0);
`endif
        end

        // Randomized traffic with occasional reset, compared cycle by cycle to the model.
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            data0 = W'($urandom);
            data1 = W'($urandom);
            cycle();
            check_model($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d_excl", n), {31'd0, grant0 & grant1}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
